fifo_fill_arbiter: RTL and testbench
====================================

// Module: fifo_fill_arbiter
// PURPOSE
//  Shares the single BRAM read port of the feature buffer between NUM_REQ FIFO fill controllers (image, weight, ...).
//  Arbitration is round-robin, with an optional row lock. BRAM read latency is pipelined.
//  Returned data is tagged with the winner's id and FIFO write mask, so it lands in the correct PE FIFOs.
//  Sits between the fill controllers and the BRAM; the FIFOs are written directly from out_*.
// PARAMETERS
//  NUM_REQ    2   number of requesting fill controllers (1..8)
//  ADDR_W     14  BRAM word address width
//  DATA_W     16  BRAM data width
//  MASK_W     9   FIFO write-enable mask width (array_size)
//  RD_LAT     2   BRAM address-to-dout latency in clk cycles (1..4)
//  BURST_MAX  16  max consecutive locked grants before forced rotation
// PORTS
//  clk        in   1               clock, rising edge
//  reset      in   1               asynchronous, active-low
//  enable     in   1               1: grants allowed; 0: no new grants, in-flight reads drain
//  req_valid  in   NUM_REQ         requester i has a read pending
//  req_lock   in   NUM_REQ         requester i asks to keep the grant (row in progress)
//  req_addr   in   NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
//  req_mask   in   NUM_REQ*MASK_W  packed FIFO write mask per requester
//  req_ready  out  NUM_REQ         one-hot grant; transfer when req_valid[i]&&req_ready[i]
//  bram_en    out  1               BRAM read enable (registered)
//  bram_addr  out  ADDR_W          BRAM read address (registered)
//  bram_dout  in   DATA_W          BRAM read data, valid RD_LAT cycles after bram_en
//  out_valid  out  NUM_REQ         one-hot: returning word belongs to requester i
//  out_mask   out  MASK_W          FIFO write mask for the returning word
//  out_data   out  DATA_W          = bram_dout (combinational pass-through)
//  busy       out  1               any read in flight (address stage or tag pipe)
// BEHAVIOUR
//  Reset:
//   - all state cleared asynchronously.
//   - req_ready=0, bram_en=0, bram_addr=0, out_valid=0, out_mask=0, busy=0.
//   - Priority pointer = 0, burst counter = 0.
//  Arbitration (combinational, same cycle):
//   - When enable=1, the first i with req_valid[i]=1, scanning from ptr upward with wrap, gets req_ready[i]=1.
//   - At most one bit is set. req_ready is never asserted without req_valid.
//   - When enable=0, req_ready=0.
//  Accept at cycle T:
//   - T+1: bram_en=1, bram_addr=req_addr[i].
//   - T+1+RD_LAT: out_valid[i]=1, out_mask=req_mask[i], out_data valid.
//   - Throughput is 1 read/cycle. Tags travel in a (RD_LAT+1)-deep {valid, id, mask} shift register.
//  Pointer update on accept of i:
//   - req_lock[i]=1 and burst<BURST_MAX-1: ptr stays i, burst+1.
//   - Otherwise ptr=(i+1)%NUM_REQ and burst=0.
//   - Lock is honoured only while req_valid[i] stays 1. A cycle with no accept clears burst; ptr is unchanged.
//  No output backpressure:
//   - Each requester must gate req_valid on its own FIFO-full state.
//   - The arbiter never drops or stalls a returning word.
//  enable falling mid-operation:
//   - Accepted reads still complete.
//   - busy stays 1 until the last out_valid cycle, then drops the next cycle.
//  Reset mid-operation: the tag pipe is cleared; in-flight BRAM data is discarded and no out_valid is raised.
//  Simultaneous events:
//   - All requesters valid: strict rotation 0,1,..,NUM_REQ-1 (no locks).
//   - A single valid requester is granted every cycle.
//  States: IDLE (nothing in flight) / ACTIVE (busy=1).
//   - IDLE->ACTIVE on accept.
//   - ACTIVE->IDLE when the tag pipe is empty and there is no accept.
// STRUCTURE
//  Shared include fill_pkg.vh:
//   - ADDR_W, DATA_W, MASK_W defaults.
//   - Tag field offsets {valid, id[$clog2(NUM_REQ)], mask}.
//   - BRAM latency constant shared with fifo fill controllers.
//  Sub-module rr_arbiter (NUM_REQ): req, lock, accept in; one-hot grant, ptr/burst state.
//  Top-level: request mux, address register, tag shift register, output decode.
// TESTING
//  1. Reset with req_valid=2'b11: req_ready=0, bram_en=0, out_valid=0 until release. First grant goes to req0.
//  2. Both valid, no lock, addr0=0x010, addr1=0x200, RD_LAT=2: grants alternate 0,1,0.
//     bram_addr goes 0x010,0x200,... from T+1; out_valid 01,10,... from T+3.
//  3. req_lock[0]=1, both valid, BURST_MAX=16: exactly 16 consecutive req0 grants, then one req1 grant.
//  4. Only req1 valid for 8 cycles, mask=9'h0F0: 8 back-to-back reads.
//     out_mask=0x0F0 and out_valid=2'b10 on 8 consecutive cycles.
//  5. enable dropped 1 cycle after 3 accepts: no new req_ready.
//     3 out_valid pulses still appear; busy falls 1 cycle after the last one.
//  6. reset asserted while 2 reads are in flight: out_valid stays 0 after reset.
//     The next accept after release returns correctly tagged data.

Source files
------------

// File: rtl/fifo_fill_arbiter_pkg.sv
// Shared definitions for the feature-buffer fill arbiter: default widths,
// the BRAM read latency seen by the fill controllers, and the FSM encoding.
package fifo_fill_arbiter_pkg;

  localparam int FILL_NUM_REQ   = 2;
  localparam int FILL_ADDR_W    = 14;
  localparam int FILL_DATA_W    = 16;
  localparam int FILL_MASK_W    = 9;
  localparam int FILL_RD_LAT    = 2;
  localparam int FILL_BURST_MAX = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } arb_state_e;

  // Requester id width; a single requester still carries a 1-bit id.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/fifo_fill_arbiter_rr_arbiter.sv
// Round-robin arbiter with row lock: one-hot grant from a rotating priority
// pointer, plus a burst counter that bounds how long a lock can hold the port.
module fifo_fill_arbiter_rr_arbiter
  import fifo_fill_arbiter_pkg::*;
#(
  parameter  int NUM_REQ   = FILL_NUM_REQ,
  parameter  int BURST_MAX = FILL_BURST_MAX,
  localparam int ID_W      = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_enable,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_lock,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_accept,
  output logic [ID_W-1:0]    o_grant_id
);

  localparam int BURST_W = $clog2(BURST_MAX + 1);

  logic [ID_W-1:0]    r_ptr;
  logic [BURST_W-1:0] r_burst;
  logic [ID_W-1:0]    w_next_ptr;
  logic               w_keep;

  // Scan from the pointer upward first, then wrap to the indices below it.
  always_comb begin
    logic found;
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    found      = 1'b0;
    o_grant    = '0;
    o_grant_id = '0;
    if (i_enable) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && i_req[i] && (i >= int'(r_ptr))) begin
          found      = 1'b1;
          o_grant[i] = 1'b1;
          o_grant_id = ID_W'(i);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && i_req[i] && (i < int'(r_ptr))) begin
          found      = 1'b1;
          o_grant[i] = 1'b1;
          o_grant_id = ID_W'(i);
        end
      end
    end
  end

  assign o_accept   = |o_grant;
  assign w_keep     = i_lock[o_grant_id] && (r_burst < BURST_W'(BURST_MAX - 1));
  assign w_next_ptr = (o_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : o_grant_id + ID_W'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_burst <= '0;
    end else if (o_accept) begin
      if (w_keep) begin
        r_ptr   <= o_grant_id;
        r_burst <= r_burst + BURST_W'(1);
      end else begin
        r_ptr   <= w_next_ptr;
        r_burst <= '0;
      end
    end else begin
      r_burst <= '0;
    end
  end

endmodule

// File: rtl/fifo_fill_arbiter.sv
// Shares the feature-buffer BRAM read port between fill controllers; returning
// words are tagged with the winner id and FIFO write mask via a tag pipe.
module fifo_fill_arbiter
  import fifo_fill_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = FILL_NUM_REQ,
  parameter int ADDR_W    = FILL_ADDR_W,
  parameter int DATA_W    = FILL_DATA_W,
  parameter int MASK_W    = FILL_MASK_W,
  parameter int RD_LAT    = FILL_RD_LAT,
  parameter int BURST_MAX = FILL_BURST_MAX
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*MASK_W-1:0] req_mask,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      bram_en,
  output logic [ADDR_W-1:0]         bram_addr,
  input  logic [DATA_W-1:0]         bram_dout,
  output logic [NUM_REQ-1:0]        out_valid,
  output logic [MASK_W-1:0]         out_mask,
  output logic [DATA_W-1:0]         out_data,
  output logic                      busy
);

  localparam int ID_W = id_width(NUM_REQ);

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [MASK_W-1:0] mask;
  } tag_t;

  logic               w_arb_en;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_accept;
  logic [ID_W-1:0]    w_grant_id;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [MASK_W-1:0]  w_sel_mask;
  logic               w_pipe_pending;
  tag_t               w_out_tag;

  logic               r_bram_en;
  logic [ADDR_W-1:0]  r_bram_addr;
  tag_t               r_tag [RD_LAT+1];
  arb_state_e         r_state;
  logic               r_busy;

  // No grant is offered while reset is held, so nothing is accepted into a
  // pipe that is being cleared.
  assign w_arb_en = enable & reset;

  fifo_fill_arbiter_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .BURST_MAX (BURST_MAX)
  ) u_rr (
    .clk        (clk),
    .reset      (reset),
    .i_enable   (w_arb_en),
    .i_req      (req_valid),
    .i_lock     (req_lock),
    .o_grant    (w_grant),
    .o_accept   (w_accept),
    .o_grant_id (w_grant_id)
  );

  // Grant is one-hot, so a plain select per requester forms the mux.
  always_comb begin
    w_sel_addr = '0;
    w_sel_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_mask = req_mask[i*MASK_W +: MASK_W];
      end
    end
  end

  // Stage 0 lines up with the BRAM address register; stage RD_LAT lines up
  // with bram_dout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bram_en   <= 1'b0;
      r_bram_addr <= '0;
      // NOTE: this register array is reset, unlike a data RAM, because a
      // stale valid bit would raise out_valid for a read that was discarded.
      for (int k = 0; k <= RD_LAT; k++) r_tag[k] <= '0;
    end else begin
      r_bram_en <= w_accept;
      if (w_accept) r_bram_addr <= w_sel_addr;
      r_tag[0] <= w_accept ? tag_t'{valid: 1'b1, id: w_grant_id, mask: w_sel_mask} : '0;
      for (int k = 1; k <= RD_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  // Reads still in flight after the current edge, excluding the output stage.
  always_comb begin
    w_pipe_pending = 1'b0;
    for (int k = 0; k < RD_LAT; k++) w_pipe_pending = w_pipe_pending | r_tag[k].valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_ACTIVE;
            r_busy  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!w_accept && !w_pipe_pending) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_out_tag = r_tag[RD_LAT];

  always_comb begin
    out_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      out_valid[i] = w_out_tag.valid && (w_out_tag.id == ID_W'(i));
  end

  assign out_mask  = w_out_tag.mask;
  assign out_data  = bram_dout;
  assign req_ready = w_grant;
  assign bram_en   = r_bram_en;
  assign bram_addr = r_bram_addr;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fifo_fill_arbiter.sv
// Directed bench for fifo_fill_arbiter: reset, rotation, lock bursts,
// back-to-back single requester, enable drop and mid-flight reset.
module tb_fifo_fill_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 16;
  localparam int MASK_W    = 9;
  localparam int RD_LAT    = 2;
  localparam int BURST_MAX = 16;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic                      enable = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_lock = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*MASK_W-1:0] req_mask = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      bram_en;
  logic [ADDR_W-1:0]         bram_addr;
  logic [DATA_W-1:0]         bram_dout;
  logic [NUM_REQ-1:0]        out_valid;
  logic [MASK_W-1:0]         out_mask;
  logic [DATA_W-1:0]         out_data;
  logic                      busy;

  logic [DATA_W-1:0] dly0, dly1;
  int n_total = 0;
  int n_bad   = 0;

  fifo_fill_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MASK_W(MASK_W), .RD_LAT(RD_LAT), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_mask(req_mask), .req_ready(req_ready),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .out_valid(out_valid), .out_mask(out_mask), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {2'b10, a ^ 14'h2A55};
  endfunction

  // BRAM model with a two-cycle address-to-dout latency.
  always @(posedge clk) begin
    dly0 <= bram_en ? mem_word(bram_addr) : 16'hDEAD;
    dly1 <= dly0;
  end
  assign bram_dout = dly1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [MASK_W-1:0] m);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_mask[i*MASK_W +: MASK_W] = m;
  endtask

  task automatic apply_reset();
    tick();
    reset = 1'b0; enable = 1'b1; req_valid = '0; req_lock = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; req_valid = 2'b11;
    set_req(0, 14'h010, 9'h001);
    set_req(1, 14'h200, 9'h002);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_total++;
      if ({req_ready, bram_en, out_valid, busy} !== 6'b0) begin
        n_bad++;
        $display("FAIL reset_outs c=%0d got rdy=%b en=%b ov=%b busy=%b exp all 0", c, req_ready, bram_en, out_valid, busy);
      end
      n_total++;
      if ({bram_addr, out_mask} !== '0) begin
        n_bad++;
        $display("FAIL reset_regs c=%0d got addr=%h mask=%h exp 0", c, bram_addr, out_mask);
      end
    end
    tick();
    reset = 1'b1;
    #1;
    n_total++;
    if (req_ready !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_first_grant got=%b exp=01", req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_rotation();
    logic [1:0]        rv   [0:6] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0]        rdy  [0:6] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    logic              en   [0:6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [ADDR_W-1:0] ad   [0:6] = '{14'h0, 14'h010, 14'h200, 14'h010, 14'h0, 14'h0, 14'h0};
    logic [1:0]        ov   [0:6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
    logic [MASK_W-1:0] om   [0:6] = '{9'h0, 9'h0, 9'h0, 9'h001, 9'h002, 9'h001, 9'h0};
    logic [ADDR_W-1:0] da   [0:6] = '{14'h0, 14'h0, 14'h0, 14'h010, 14'h200, 14'h010, 14'h0};
    logic              bz   [0:6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    set_req(0, 14'h010, 9'h001);
    set_req(1, 14'h200, 9'h002);
    for (int c = 0; c < 7; c++) begin
      req_valid = rv[c];
      #1;
      n_total++;
      if (req_ready !== rdy[c] || bram_en !== en[c] || busy !== bz[c]) begin
        n_bad++;
        $display("FAIL rot_ctrl c=%0d got rdy=%b en=%b busy=%b exp rdy=%b en=%b busy=%b",
                 c, req_ready, bram_en, busy, rdy[c], en[c], bz[c]);
      end
      if (en[c]) begin
        n_total++;
        if (bram_addr !== ad[c]) begin
          n_bad++;
          $display("FAIL rot_addr c=%0d got=%h exp=%h", c, bram_addr, ad[c]);
        end
      end
      n_total++;
      if (out_valid !== ov[c] || out_mask !== om[c]) begin
        n_bad++;
        $display("FAIL rot_out c=%0d got ov=%b mask=%h exp ov=%b mask=%h", c, out_valid, out_mask, ov[c], om[c]);
      end
      if (ov[c] != 2'b00) begin
        n_total++;
        if (out_data !== mem_word(da[c])) begin
          n_bad++;
          $display("FAIL rot_data c=%0d got=%h exp=%h", c, out_data, mem_word(da[c]));
        end
      end
      tick();
    end
  endtask

  task automatic test_lock_burst();
    logic [1:0] exp_rdy;
    apply_reset();
    set_req(0, 14'h040, 9'h00F);
    set_req(1, 14'h080, 9'h0F0);
    req_lock = 2'b01;
    for (int c = 0; c < 18; c++) begin
      req_valid = 2'b11;
      #1;
      exp_rdy = (c == 16) ? 2'b10 : 2'b01;
      n_total++;
      if (req_ready !== exp_rdy) begin
        n_bad++;
        $display("FAIL lock_grant c=%0d got=%b exp=%b", c, req_ready, exp_rdy);
      end
      tick();
    end
    req_valid = '0;
    req_lock  = '0;
    repeat (RD_LAT + 3) tick();
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    apply_reset();
    set_req(0, 14'h000, 9'h00F);
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8) ? 2'b10 : 2'b00;
      set_req(1, ADDR_W'(32'h300 + c), 9'h0F0);
      #1;
      n_total++;
      if (req_ready !== ((c < 8) ? 2'b10 : 2'b00)) begin
        n_bad++;
        $display("FAIL b2b_grant c=%0d got=%b", c, req_ready);
      end
      if (c >= 3 && c < 11) begin
        a = ADDR_W'(32'h300 + c - 3);
        n_total++;
        if (out_valid !== 2'b10 || out_mask !== 9'h0F0 || out_data !== mem_word(a)) begin
          n_bad++;
          $display("FAIL b2b_out c=%0d got ov=%b mask=%h data=%h exp ov=10 mask=0f0 data=%h",
                   c, out_valid, out_mask, out_data, mem_word(a));
        end
      end else begin
        n_total++;
        if (out_valid !== 2'b00) begin
          n_bad++;
          $display("FAIL b2b_idle c=%0d got ov=%b exp=00", c, out_valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_enable_drop();
    logic [1:0] rdy [0:8] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] ov  [0:8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    logic       en  [0:8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       bz  [0:8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    apply_reset();
    set_req(0, 14'h111, 9'h003);
    set_req(1, 14'h222, 9'h00C);
    for (int c = 0; c < 9; c++) begin
      enable    = (c < 3);
      req_valid = 2'b11;
      #1;
      n_total++;
      if (req_ready !== rdy[c] || out_valid !== ov[c] || bram_en !== en[c] || busy !== bz[c]) begin
        n_bad++;
        $display("FAIL endrop c=%0d got rdy=%b ov=%b en=%b busy=%b exp rdy=%b ov=%b en=%b busy=%b",
                 c, req_ready, out_valid, bram_en, busy, rdy[c], ov[c], en[c], bz[c]);
      end
      tick();
    end
    req_valid = '0;
    enable    = 1'b1;
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    set_req(0, 14'h0AA, 9'h011);
    set_req(1, 14'h0BB, 9'h022);
    req_valid = 2'b11;
    tick();
    #1;
    n_total++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_busy got=%b exp=1", busy);
    end
    tick();
    reset = 1'b0;
    req_valid = '0;
    #1;
    n_total++;
    if (out_valid !== 2'b00 || busy !== 1'b0 || bram_en !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_clear got ov=%b busy=%b en=%b exp 0", out_valid, busy, bram_en);
    end
    for (int c = 3; c < 5; c++) begin
      tick();
      if (c == 4) reset = 1'b1;
      #1;
      n_total++;
      if (out_valid !== 2'b00) begin
        n_bad++;
        $display("FAIL mid_discard c=%0d got ov=%b exp=00", c, out_valid);
      end
    end
    tick();
    req_valid = 2'b10;
    set_req(1, 14'h155, 9'h1FF);
    #1;
    n_total++;
    if (req_ready !== 2'b10) begin
      n_bad++;
      $display("FAIL mid_regrant got=%b exp=10", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    n_total++;
    if (bram_en !== 1'b1 || bram_addr !== 14'h155 || out_valid !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_addr got en=%b addr=%h ov=%b exp en=1 addr=155 ov=00", bram_en, bram_addr, out_valid);
    end
    tick();
    tick();
    #1;
    n_total++;
    if (out_valid !== 2'b10 || out_mask !== 9'h1FF || out_data !== mem_word(14'h155)) begin
      n_bad++;
      $display("FAIL mid_return got ov=%b mask=%h data=%h exp ov=10 mask=1ff data=%h",
               out_valid, out_mask, out_data, mem_word(14'h155));
    end
    tick();
    #1;
    n_total++;
    if (out_valid !== 2'b00 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_drain got ov=%b busy=%b exp 00/0", out_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_lock_burst();
    test_back_to_back();
    test_enable_drop();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
